// File: rtl/pat_tx_pkg.sv
// rtl/pat_tx_pkg.sv - shared states and frame constants for the marker-frame transmitter
package pat_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    GUARD,
    DATA,
    TAIL
  } state_e;

  localparam int   MARK_LEN  = 3;
  localparam int   RUN_MAX   = 2;
  localparam logic GUARD_BIT = 1'b0;
  localparam logic TAIL_BIT  = 1'b0;

endpackage

// File: rtl/pat_tx_sreg.sv
// rtl/pat_tx_sreg.sv - payload load/shift-right register; hold freezes it during non-data cycles
module pat_tx_sreg #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             load_i,
  input  logic             hold_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] sreg_q;

  always_ff @(negedge ck or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
    end else if (!hold_i) begin
      sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  assign lsb_o = sreg_q[0];

endmodule

// File: rtl/pat_tx.sv
// rtl/pat_tx.sv - serial marker-frame transmitter (111 marker, guard 0, LSB-first data, tail 0)
// Zero-stuffing of the data section is built only when PAT_TX_STUFF_EN is defined.
module pat_tx
  import pat_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             a,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e           state_q;
  logic             a_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       mcnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             last_q;
  logic             lsb;
  logic             load;
  logic             shift;
  logic             stuff_now;

`ifdef PAT_TX_STUFF_EN
  logic [1:0] run_q;
  logic [1:0] run_base;

  // GUARD clears the run, so the first data bit counts from zero.
  assign run_base  = (state_q == GUARD) ? 2'd0 : run_q;
  assign stuff_now = (state_q == DATA) && !last_q && (run_q == 2'(RUN_MAX));
`else
  assign stuff_now = 1'b0;
`endif

  assign load  = (state_q == IDLE) && start;
  assign shift = (state_q == GUARD) || ((state_q == DATA) && !last_q && !stuff_now);

  pat_tx_sreg #(.WIDTH(WIDTH)) u_sreg (
    .ck     (ck),
    .rst    (rst),
    .load_i (load),
    .hold_i (!shift),
    .data_i (data),
    .lsb_o  (lsb)
  );

  always_ff @(negedge ck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mcnt_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
`ifdef PAT_TX_STUFF_EN
      run_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          a_q    <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            busy_q  <= 1'b1;
            a_q     <= 1'b1;
            mcnt_q  <= 2'd1;
            idx_q   <= '0;
            last_q  <= 1'b0;
            state_q <= MARK;
          end
        end
        MARK: begin
          if (mcnt_q == 2'(MARK_LEN)) begin
            a_q     <= GUARD_BIT;
            state_q <= GUARD;
          end else begin
            a_q    <= 1'b1;
            mcnt_q <= mcnt_q + 2'd1;
          end
        end
        GUARD, DATA: begin
          // The tail 0 breaks any run left by the final bit, so no stuff is needed there.
          if ((state_q == DATA) && last_q) begin
            a_q     <= TAIL_BIT;
            done_q  <= 1'b1;
            last_q  <= 1'b0;
            state_q <= TAIL;
          end else if (stuff_now) begin
            a_q <= 1'b0;
`ifdef PAT_TX_STUFF_EN
            run_q <= '0;
`endif
          end else begin
            a_q     <= lsb;
            idx_q   <= idx_q + 1'b1;
            last_q  <= (idx_q == IDX_W'(WIDTH - 1));
            state_q <= DATA;
`ifdef PAT_TX_STUFF_EN
            run_q <= lsb ? run_base + 2'd1 : 2'd0;
`endif
          end
        end
        TAIL: begin
          a_q     <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a    = a_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pat_tx.sv
// tb/tb_pat_tx.sv - directed checks of pat_tx frames; expectations follow PAT_TX_STUFF_EN
module tb_pat_tx;

  logic       ck;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       a;
  logic       busy;
  logic       done;

  int n_checks;
  int n_pass;

  pat_tx #(.WIDTH(8)) dut (
    .ck    (ck),
    .rst   (rst),
    .start (start),
    .data  (data),
    .a     (a),
    .busy  (busy),
    .done  (done)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

`ifdef PAT_TX_STUFF_EN
  localparam string EXP_FF = "1110110110110110";
  localparam string EXP_B6 = "111001100110010";
`else
  localparam string EXP_FF = "1110111111110";
  localparam string EXP_B6 = "1110011011010";
`endif
  localparam string EXP_00 = "1110000000000";

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; data = 8'h00;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (a !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_outputs: a=%b busy=%b done=%b, want 0 0 0", a, busy, done);
    else n_pass++;
    repeat (2) @(negedge ck);
    @(posedge ck);
    rst = 1'b0;
    repeat (2) @(posedge ck);
    n_checks++;
    if (a !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_reset: a=%b busy=%b done=%b, want 0 0 0", a, busy, done);
    else n_pass++;
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input string exp_a, input int pulse_at);
    string obs;
    int    len, done_cnt, done_pos, c, busy_seen;
    bit    ended;
    logic  end_a, end_done;
    obs = ""; len = 0; done_cnt = 0; done_pos = 0; c = 0; ended = 1'b0;
    end_a = 1'b0; end_done = 1'b0;
    @(posedge ck);
    data = d; start = 1'b1;
    @(negedge ck);
    #1 start = 1'b0;
    while (!ended && c < 60) begin
      @(posedge ck);
      c++;
      if (c == pulse_at) begin start = 1'b1; data = 8'hFF; end
      if (pulse_at > 0 && c == pulse_at + 1) start = 1'b0;
      if (busy) begin
        if (a) obs = {obs, "1"}; else obs = {obs, "0"};
        len++;
        if (done) begin done_cnt++; done_pos = c; end
      end else begin
        ended = 1'b1; end_a = a; end_done = done;
      end
    end
    n_checks++;
    if (!ended) $display("FAIL %s_timeout: busy still high after %0d cycles, want low", name, c);
    else n_pass++;
    n_checks++;
    if (obs != exp_a) $display("FAIL %s_bits: got %s want %s", name, obs, exp_a);
    else n_pass++;
    n_checks++;
    if (len != exp_a.len()) $display("FAIL %s_length: got %0d want %0d", name, len, exp_a.len());
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || done_pos != exp_a.len())
      $display("FAIL %s_done: pulses=%0d at cycle %0d, want 1 at cycle %0d", name, done_cnt, done_pos, exp_a.len());
    else n_pass++;
    n_checks++;
    if (end_a !== 1'b0 || end_done !== 1'b0)
      $display("FAIL %s_end: a=%b done=%b after frame, want 0 0", name, end_a, end_done);
    else n_pass++;
    if (pulse_at > 0) begin
      busy_seen = 0;
      repeat (10) begin
        @(posedge ck);
        if (busy || a) busy_seen++;
      end
      n_checks++;
      if (busy_seen != 0) $display("FAIL %s_no_second_frame: %0d active cycles, want 0", name, busy_seen);
      else n_pass++;
    end
    data = 8'h00;
  endtask

  task automatic test_frames();
    run_frame("zero", 8'h00, EXP_00, 0);
    run_frame("ones", 8'hFF, EXP_FF, 0);
    run_frame("b6",   8'hB6, EXP_B6, 0);
  endtask

  task automatic test_ignore_start();
    run_frame("ignore", 8'h00, EXP_00, 5);
  endtask

  task automatic test_back_to_back();
    string oa, ob;
    int    c;
    oa = ""; ob = "";
    @(posedge ck);
    data = 8'h00; start = 1'b1;
    @(negedge ck);
    for (int i = 0; i < 30; i++) begin
      @(posedge ck);
      if (a) oa = {oa, "1"}; else oa = {oa, "0"};
      if (busy) ob = {ob, "1"}; else ob = {ob, "0"};
    end
    start = 1'b0;
    n_checks++;
    if (oa != {EXP_00, "0", EXP_00, "0", "11"})
      $display("FAIL b2b_bits: got %s want %s", oa, {EXP_00, "0", EXP_00, "0", "11"});
    else n_pass++;
    n_checks++;
    if (ob != "111111111111101111111111111011")
      $display("FAIL b2b_busy: got %s want 111111111111101111111111111011", ob);
    else n_pass++;
    c = 0;
    while (busy && c < 40) begin @(posedge ck); c++; end
    n_checks++;
    if (busy) $display("FAIL b2b_drain: busy=%b after %0d cycles, want 0", busy, c);
    else n_pass++;
    repeat (2) @(posedge ck);
  endtask

  task automatic test_reset_mid();
    @(posedge ck);
    data = 8'hFF; start = 1'b1;
    @(negedge ck);
    #1 start = 1'b0;
    repeat (6) @(posedge ck);
    n_checks++;
    if (busy !== 1'b1 || a !== 1'b1)
      $display("FAIL mid_precheck: busy=%b a=%b, want 1 1", busy, a);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (a !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_reset_async: a=%b busy=%b done=%b, want 0 0 0", a, busy, done);
    else n_pass++;
    @(posedge ck);
    rst = 1'b0;
    run_frame("after_rst", 8'hFF, EXP_FF, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_frames();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
